riscv_multicycle_ctrl: RTL and testbench
========================================

Name: riscv_multicycle_ctrl

Overview:
- Moore-style control FSM for the multicycle RV32I datapath: shared instruction/data memory, single ALU, architectural registers PC, OldPC, Instr, Data, A, WriteData, ALUOut.
- Sequences each instruction over 2-5 cycles and drives every datapath select/enable.
- Supersedes the single-cycle main decoder when the multicycle core is built; the instruction subset is unchanged: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- none; encodings are fixed in the package

Ports:
- clk         in   1  core clock; rising-edge
- reset       in   1  asynchronous, active-high; clears FSM to FETCH
- op          in   7  Instr[6:0], valid from DECODE onward
- funct3      in   3  Instr[14:12]
- funct7b5    in   1  Instr[30]
- Zero        in   1  ALU zero flag, same cycle
- PCWrite     out  1  PC register enable
- AdrSrc      out  1  memory address: 0=PC, 1=Result
- MemWrite    out  1  memory write enable
- IRWrite     out  1  Instr/OldPC register enable
- ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA     out  2  00=PC, 01=OldPC, 10=A
- ALUSrcB     out  2  00=WriteData, 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc      out  2  00 I, 01 S, 10 B, 11 J
- RegWrite    out  1  register-file write enable
- state_o     out  4  current state, for debug/verification

Behaviour:
- Single state register, asynchronous clear to FETCH on reset. While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- Every output is a function of state only, except:
  - PCWrite = PCUpdate | (Branch & Zero)
  - ImmSrc, derived from op alone
  - ALUControl, derived from ALUOp, funct3, op[5] and funct7b5
- Unlisted outputs in a state are 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - FETCH->DECODE.
  - From DECODE, by op:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other -> FETCH (NOP; no architectural write)
  - From MEMADR: op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
  - MEMREAD->MEMWB.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
  - Undefined state encodings -> FETCH.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R/I-type 4, jal 4, beq 3, unimplemented 2.
- ImmSrc: lw and I-type 00, sw 01, beq 10, jal 11, other 00.
- ALU decode:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if op[5]&funct7b5, else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other -> add
  - ALUOp 11 -> add.
- Reset asserted mid-instruction: immediate return to FETCH; no partial write completes after reset assertion. First FETCH occurs on the first rising edge after deassertion.

Decomposition:
- Package riscv_mc_pkg holds:
  - state enum statetype_t (4-bit)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUOp encodings
  - ALUControl encodings
  - ImmSrc encodings
- One sub-module, riscv_aludec: combinational ALUOp/funct3/op5/funct7b5 -> ALUControl.
- FSM, output decode and ImmSrc decode live in the top.

Test Plan:
- Release reset, op=0000011 -> state_o sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. IRWrite=1 only in FETCH; RegWrite=1 with ResultSrc=01 only in MEMWB.
- op=0100011 -> MEMWRITE reached in cycle 3 with MemWrite=1, AdrSrc=1, ImmSrc=01. Next state is FETCH; RegWrite is never asserted.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER. Repeat with funct7b5=0 -> 000. op=0010011, funct3=000, funct7b5=1 -> 000 (addi, not sub).
- op=1100011: Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
- op=1101111 -> JAL with PCWrite=1, ALUSrcA=01, ALUSrcB=10, then ALUWB with RegWrite=1. op=1111111 -> DECODE then FETCH with no enables.
- Assert reset during MEMWB -> state_o=FETCH immediately (async) and all write enables 0. After release, normal fetch resumes on the next edge.

Source files
------------

// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, select codes
// and the per-state control word.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_A        = 2'b10;
    localparam logic [1:0] SRCB_WD       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input statetype_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = SRCA_A;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB:    c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a = SRCA_A;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; the datapath is the master, the controller the slave.
interface riscv_multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] state_o;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, state_o
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, state_o
    );
endinterface

// File: rtl/riscv_multicycle_ctrl_aludec.sv
// ALU decoder: ALUOp class plus instruction fields select the ALU operation.
module riscv_aludec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // only R-type with funct7b5 is sub; addi carries immediate bits there
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core; the control word is registered
// alongside the state, only PCWrite, ImmSrc and ALUControl see live inputs.
module riscv_multicycle_ctrl
    import riscv_mc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    riscv_multicycle_ctrl_if.slave   bus
);
    statetype_t r_state;
    statetype_t w_next;
    ctrl_t      r_ctrl;
    logic [1:0] w_imm_src;
    logic [2:0] w_alu_control;

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECUTER;
                    OP_I:         w_next = EXECUTEI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:                  w_next = bus.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:                 w_next = MEMWB;
            EXECUTER, EXECUTEI, JAL: w_next = ALUWB;
            default:                 w_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ctrl  <= state_ctrl(FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    always_comb begin
        case (bus.op)
            OP_SW:   w_imm_src = IMM_S;
            OP_BEQ:  w_imm_src = IMM_B;
            OP_JAL:  w_imm_src = IMM_J;
            default: w_imm_src = IMM_I;
        endcase
    end

    riscv_aludec u_aludec (
        .i_alu_op      (r_ctrl.alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (w_alu_control)
    );

    // architectural write enables are held off for as long as reset is high
    assign bus.PCWrite    = ~reset & (r_ctrl.pc_update | (r_ctrl.branch & bus.Zero));
    assign bus.IRWrite    = ~reset & r_ctrl.ir_write;
    assign bus.MemWrite   = ~reset & r_ctrl.mem_write;
    assign bus.RegWrite   = ~reset & r_ctrl.reg_write;
    assign bus.AdrSrc     = r_ctrl.adr_src;
    assign bus.ResultSrc  = r_ctrl.result_src;
    assign bus.ALUSrcA    = r_ctrl.alu_src_a;
    assign bus.ALUSrcB    = r_ctrl.alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.state_o    = r_state;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Self-checking bench for riscv_multicycle_ctrl: directed vector table, reset corner
// case and randomized instruction stream against an instruction-level reference model.
module tb_riscv_multicycle_ctrl;
    import riscv_mc_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    riscv_multicycle_ctrl_if bus ();

    riscv_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         lat;
        int         ap;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       pcw_last;
        logic       rw_last;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instruction-level model: the state walk of each instruction class
    function automatic int lat_of(input logic [6:0] op);
        case (op)
            OP_LW:              return 5;
            OP_SW, OP_R, OP_I:  return 4;
            OP_JAL:             return 4;
            OP_BEQ:             return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [3:0] st_of(input logic [6:0] op, input int p);
        statetype_t seq [5];
        seq[0] = FETCH; seq[1] = DECODE; seq[2] = FETCH; seq[3] = FETCH; seq[4] = FETCH;
        case (op)
            OP_LW:  begin seq[2] = MEMADR; seq[3] = MEMREAD; seq[4] = MEMWB; end
            OP_SW:  begin seq[2] = MEMADR; seq[3] = MEMWRITE; end
            OP_R:   begin seq[2] = EXECUTER; seq[3] = ALUWB; end
            OP_I:   begin seq[2] = EXECUTEI; seq[3] = ALUWB; end
            OP_JAL: begin seq[2] = JAL; seq[3] = ALUWB; end
            OP_BEQ: seq[2] = BEQ;
            default: ;
        endcase
        return seq[p];
    endfunction

    function automatic exp_t model(input logic [3:0] s, input logic [6:0] op,
                                   input logic [2:0] f3, input logic f7, input logic zero);
        exp_t e;
        e.st  = s;
        e.irw = (s == FETCH);
        e.pcw = (s == FETCH) || (s == JAL) || ((s == BEQ) && zero);
        e.adr = (s == MEMREAD) || (s == MEMWRITE);
        e.mw  = (s == MEMWRITE);
        e.rw  = (s == MEMWB) || (s == ALUWB);
        e.rs  = (s == FETCH) ? 2'b10 : (s == MEMWB) ? 2'b01 : 2'b00;
        e.sa  = ((s == DECODE) || (s == JAL)) ? 2'b01 :
                ((s == MEMADR) || (s == EXECUTER) || (s == EXECUTEI) || (s == BEQ)) ? 2'b10 : 2'b00;
        e.sb  = ((s == FETCH) || (s == JAL)) ? 2'b10 :
                ((s == DECODE) || (s == MEMADR) || (s == EXECUTEI)) ? 2'b01 : 2'b00;
        e.imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
        e.alu = 3'b000;
        if (s == BEQ) e.alu = 3'b001;
        if ((s == EXECUTER) || (s == EXECUTEI)) begin
            case (f3)
                3'b000: e.alu = ((op == OP_R) && f7) ? 3'b001 : 3'b000;
                3'b010: e.alu = 3'b101;
                3'b110: e.alu = 3'b011;
                3'b111: e.alu = 3'b010;
                default: e.alu = 3'b000;
            endcase
        end
        return e;
    endfunction

    task automatic check_model(input exp_t e);
        chk("state_o",    32'(bus.state_o),    32'(e.st));
        chk("PCWrite",    32'(bus.PCWrite),    32'(e.pcw));
        chk("AdrSrc",     32'(bus.AdrSrc),     32'(e.adr));
        chk("MemWrite",   32'(bus.MemWrite),   32'(e.mw));
        chk("IRWrite",    32'(bus.IRWrite),    32'(e.irw));
        chk("RegWrite",   32'(bus.RegWrite),   32'(e.rw));
        chk("ResultSrc",  32'(bus.ResultSrc),  32'(e.rs));
        chk("ALUSrcA",    32'(bus.ALUSrcA),    32'(e.sa));
        chk("ALUSrcB",    32'(bus.ALUSrcB),    32'(e.sb));
        chk("ALUControl", 32'(bus.ALUControl), 32'(e.alu));
        chk("ImmSrc",     32'(bus.ImmSrc),     32'(e.imm));
    endtask

    vec_t vt [13];

    initial begin
        int seen;
        logic [6:0] rop;
        logic [2:0] rf3;
        logic       rf7;
        logic       rz;
        int         L;
        logic [6:0] ops [6];

        n_assert = 0;
        n_fail   = 0;
        //          op       f3      f7    zero  lat ap alu     imm    pcw   rw
        vt[0]  = '{OP_LW,  3'b000, 1'b0, 1'b0, 5, 2, 3'b000, 2'b00, 1'b0, 1'b1};
        vt[1]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 4, 2, 3'b000, 2'b01, 1'b0, 1'b0};
        vt[2]  = '{OP_R,   3'b000, 1'b1, 1'b0, 4, 2, 3'b001, 2'b00, 1'b0, 1'b1};
        vt[3]  = '{OP_R,   3'b000, 1'b0, 1'b0, 4, 2, 3'b000, 2'b00, 1'b0, 1'b1};
        vt[4]  = '{OP_I,   3'b000, 1'b1, 1'b0, 4, 2, 3'b000, 2'b00, 1'b0, 1'b1};
        vt[5]  = '{OP_R,   3'b010, 1'b0, 1'b0, 4, 2, 3'b101, 2'b00, 1'b0, 1'b1};
        vt[6]  = '{OP_R,   3'b110, 1'b0, 1'b0, 4, 2, 3'b011, 2'b00, 1'b0, 1'b1};
        vt[7]  = '{OP_I,   3'b111, 1'b0, 1'b0, 4, 2, 3'b010, 2'b00, 1'b0, 1'b1};
        vt[8]  = '{OP_R,   3'b001, 1'b1, 1'b0, 4, 2, 3'b000, 2'b00, 1'b0, 1'b1};
        vt[9]  = '{OP_BEQ, 3'b000, 1'b0, 1'b1, 3, 2, 3'b001, 2'b10, 1'b1, 1'b0};
        vt[10] = '{OP_BEQ, 3'b000, 1'b0, 1'b0, 3, 2, 3'b001, 2'b10, 1'b0, 1'b0};
        vt[11] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4, 2, 3'b000, 2'b11, 1'b0, 1'b1};
        vt[12] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 1, 3'b000, 2'b00, 1'b0, 1'b0};

        reset = 1'b1;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b1;
        #3;
        chk("rst_state",    32'(bus.state_o),   32'(FETCH));
        chk("rst_IRWrite",  32'(bus.IRWrite),   32'd0);
        chk("rst_PCWrite",  32'(bus.PCWrite),   32'd0);
        chk("rst_MemWrite", 32'(bus.MemWrite),  32'd0);
        chk("rst_RegWrite", 32'(bus.RegWrite),  32'd0);
        chk("rst_ALUSrcB",  32'(bus.ALUSrcB),   32'd2);
        chk("rst_ResultSrc",32'(bus.ResultSrc), 32'd2);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            seen = 0;
            for (int p = 0; p < 8 && seen == 0; p++) begin
                bus.op = vt[i].op; bus.funct3 = vt[i].f3;
                bus.funct7b5 = vt[i].f7; bus.Zero = vt[i].zero;
                #1;
                if (p == 0) chk("vec_fetch", 32'(bus.state_o), 32'(FETCH));
                if (p == vt[i].ap) begin
                    chk("vec_alu", 32'(bus.ALUControl), 32'(vt[i].alu));
                    chk("vec_imm", 32'(bus.ImmSrc), 32'(vt[i].imm));
                end
                if (p == vt[i].lat - 1) begin
                    chk("vec_pcw_last", 32'(bus.PCWrite), 32'(vt[i].pcw_last));
                    chk("vec_rw_last",  32'(bus.RegWrite), 32'(vt[i].rw_last));
                end
                tick();
                if (bus.state_o == FETCH) seen = p + 1;
            end
            chk("vec_latency", 32'(seen), 32'(vt[i].lat));
        end

        // reset dropped onto a load in its write-back cycle
        bus.op = OP_LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
        for (int p = 0; p < 4; p++) tick();
        #1;
        chk("mwb_state",    32'(bus.state_o),  32'(MEMWB));
        chk("mwb_RegWrite", 32'(bus.RegWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_state",    32'(bus.state_o),  32'(FETCH));
        chk("arst_RegWrite", 32'(bus.RegWrite), 32'd0);
        chk("arst_IRWrite",  32'(bus.IRWrite),  32'd0);
        chk("arst_PCWrite",  32'(bus.PCWrite),  32'd0);
        chk("arst_MemWrite", 32'(bus.MemWrite), 32'd0);
        tick();
        chk("arst_hold", 32'(bus.state_o), 32'(FETCH));
        reset = 1'b0;
        #1;
        chk("rel_IRWrite", 32'(bus.IRWrite), 32'd1);
        chk("rel_state",   32'(bus.state_o), 32'(FETCH));
        tick();
        chk("rel_decode",  32'(bus.state_o), 32'(DECODE));
        reset = 1'b1;
        #1;
        reset = 1'b0;

        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
        ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
        for (int n = 0; n < 80; n++) begin
            L = $urandom_range(0, 7);
            rop = (L < 6) ? ops[L] : 7'($urandom);
            rf3 = 3'($urandom);
            rf7 = 1'($urandom);
            L = lat_of(rop);
            for (int p = 0; p < L; p++) begin
                rz = 1'($urandom);
                bus.op = rop; bus.funct3 = rf3; bus.funct7b5 = rf7; bus.Zero = rz;
                #1;
                check_model(model(st_of(rop, p), rop, rf3, rf7, rz));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
